// File: rtl/block_ram_arbiter.sv
// block_ram_arbiter: clears a shared single-port block RAM after reset, then round-robin arbitrates two requesters onto it
module block_ram_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int INDEX_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [1:0]                       reqValid,
  input  logic [1:0]                       reqWrite,
  input  logic [1:0][INDEX_WIDTH-1:0]      reqIndex,
  input  logic [1:0][DATA_WIDTH-1:0]       reqWriteValue,
  output logic [1:0]                       reqReady,
  output logic [1:0]                       respValid,
  output logic [DATA_WIDTH-1:0]            respValue,
  output logic                             initDone,
  output logic [INDEX_WIDTH-1:0]           ramIndex,
  output logic [DATA_WIDTH-1:0]            ramWriteValue,
  output logic                             ramWriteEnable,
  input  logic [DATA_WIDTH-1:0]            ramReadValue
);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t                 state;
  logic [INDEX_WIDTH-1:0] clear_index;
  logic [INDEX_WIDTH-1:0] last_index;
  logic                   rr_ptr;
  logic                   done_q;
  logic [1:0]             resp_q;
  logic                   gid;
  logic                   grant;
  always_comb begin
    gid            = &reqValid ? rr_ptr : reqValid[1];
    grant          = !rst && state == RUN && |reqValid;
    reqReady       = grant ? (gid ? 2'b10 : 2'b01) : 2'b00;
    ramWriteEnable = !rst && (state == CLEAR || (grant && reqWrite[gid]));
    ramIndex       = state == CLEAR ? clear_index : grant ? reqIndex[gid] : last_index;
    ramWriteValue  = state == CLEAR ? '0 : reqWriteValue[gid];
  end
  // outputs are forced low for the whole reset cycle, not just after the edge
  assign respValid = rst ? 2'b00 : resp_q;
  assign respValue = ramReadValue;
  assign initDone  = !rst && done_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= CLEAR;
      clear_index <= '0;
      last_index  <= '0;
      rr_ptr      <= 1'b0;
      done_q      <= 1'b0;
      resp_q      <= 2'b00;
    end else begin
      last_index <= ramIndex;
      resp_q     <= (grant && !reqWrite[gid]) ? reqReady : 2'b00;
      if (grant) rr_ptr <= !gid;
      if (state == CLEAR) begin
        clear_index <= clear_index + 1'b1;
        if (&clear_index) begin
          state  <= RUN;
          done_q <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_block_ram_arbiter.sv
// tb_block_ram_arbiter: directed table, corner sequences and random traffic against a memory/round-robin model
module tb_block_ram_arbiter;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int N  = 16;
  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [1:0]           reqValid = '0;
  logic [1:0]           reqWrite = '0;
  logic [1:0][IW-1:0]   reqIndex = '0;
  logic [1:0][DW-1:0]   reqWriteValue = '0;
  logic [1:0]           reqReady;
  logic [1:0]           respValid;
  logic [DW-1:0]        respValue;
  logic                 initDone;
  logic [IW-1:0]        ramIndex;
  logic [DW-1:0]        ramWriteValue;
  logic                 ramWriteEnable;
  logic [DW-1:0]        ramReadValue;
  logic [DW-1:0]        mem [N] = '{default: 32'hBAD0_BAD0};
  int errors = 0;
  int checks = 0;

  block_ram_arbiter #(.DATA_WIDTH(DW), .INDEX_WIDTH(IW)) dut (
    .clk(clk), .rst(rst), .reqValid(reqValid), .reqWrite(reqWrite), .reqIndex(reqIndex),
    .reqWriteValue(reqWriteValue), .reqReady(reqReady), .respValid(respValid), .respValue(respValue),
    .initDone(initDone), .ramIndex(ramIndex), .ramWriteValue(ramWriteValue),
    .ramWriteEnable(ramWriteEnable), .ramReadValue(ramReadValue)
  );

  always #5 clk = ~clk;

  // single-port RAM, 1-cycle read latency, read-before-write
  always @(posedge clk) begin
    ramReadValue <= mem[ramIndex];
    if (ramWriteEnable) mem[ramIndex] <= ramWriteValue;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] w, input logic [IW-1:0] i0,
                       input logic [IW-1:0] i1, input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    @(negedge clk);
    reqValid = v;
    reqWrite = w;
    reqIndex[0] = i0;
    reqIndex[1] = i1;
    reqWriteValue[0] = d0;
    reqWriteValue[1] = d1;
    #1;
  endtask

  typedef struct {
    logic [1:0] v, w;
    logic [IW-1:0] i0, i1;
    logic [DW-1:0] d0, d1;
    logic [1:0] rdy, rv;
    logic [DW-1:0] rval;
  } vec_t;
  vec_t tbl [22];

  logic [DW-1:0] mm [N];
  int            rr;
  int            g;
  logic [1:0]    pend;
  logic [1:0]    hold;
  logic [1:0]    exp_rdy;
  logic [DW-1:0] pval;

  initial begin
    tbl[0]  = '{2'b01, 2'b01, 4'd5,  4'd0, 32'hDEADBEEF, 32'h0,        2'b01, 2'b00, 32'h0};
    tbl[1]  = '{2'b01, 2'b00, 4'd5,  4'd0, 32'h0,        32'h0,        2'b01, 2'b00, 32'h0};
    tbl[2]  = '{2'b00, 2'b00, 4'd0,  4'd0, 32'h0,        32'h0,        2'b00, 2'b01, 32'hDEADBEEF};
    tbl[3]  = '{2'b10, 2'b10, 4'd0,  4'd3, 32'h0,        32'h12345678, 2'b10, 2'b00, 32'h0};
    tbl[4]  = '{2'b11, 2'b00, 4'd5,  4'd3, 32'h0,        32'h0,        2'b01, 2'b00, 32'h0};
    tbl[5]  = '{2'b11, 2'b00, 4'd5,  4'd3, 32'h0,        32'h0,        2'b10, 2'b01, 32'hDEADBEEF};
    tbl[6]  = '{2'b11, 2'b00, 4'd5,  4'd3, 32'h0,        32'h0,        2'b01, 2'b10, 32'h12345678};
    tbl[7]  = '{2'b11, 2'b00, 4'd5,  4'd3, 32'h0,        32'h0,        2'b10, 2'b01, 32'hDEADBEEF};
    tbl[8]  = '{2'b11, 2'b00, 4'd5,  4'd3, 32'h0,        32'h0,        2'b01, 2'b10, 32'h12345678};
    tbl[9]  = '{2'b11, 2'b00, 4'd5,  4'd3, 32'h0,        32'h0,        2'b10, 2'b01, 32'hDEADBEEF};
    tbl[10] = '{2'b00, 2'b00, 4'd0,  4'd0, 32'h0,        32'h0,        2'b00, 2'b10, 32'h12345678};
    tbl[11] = '{2'b01, 2'b01, 4'd15, 4'd0, 32'hA5,       32'h0,        2'b01, 2'b00, 32'h0};
    tbl[12] = '{2'b10, 2'b00, 4'd0,  4'd15, 32'h0,       32'h0,        2'b10, 2'b00, 32'h0};
    tbl[13] = '{2'b01, 2'b00, 4'd0,  4'd0, 32'h0,        32'h0,        2'b01, 2'b10, 32'hA5};
    tbl[14] = '{2'b00, 2'b00, 4'd0,  4'd0, 32'h0,        32'h0,        2'b00, 2'b01, 32'h0};
    tbl[15] = '{2'b10, 2'b10, 4'd0,  4'd7, 32'h0,        32'h11,       2'b10, 2'b00, 32'h0};
    tbl[16] = '{2'b10, 2'b00, 4'd0,  4'd7, 32'h0,        32'h0,        2'b10, 2'b00, 32'h0};
    tbl[17] = '{2'b10, 2'b10, 4'd0,  4'd7, 32'h0,        32'h22,       2'b10, 2'b10, 32'h11};
    tbl[18] = '{2'b10, 2'b00, 4'd0,  4'd7, 32'h0,        32'h0,        2'b10, 2'b00, 32'h0};
    tbl[19] = '{2'b00, 2'b00, 4'd0,  4'd0, 32'h0,        32'h0,        2'b00, 2'b10, 32'h22};
    tbl[20] = '{2'b11, 2'b00, 4'd0,  4'd0, 32'h0,        32'h0,        2'b01, 2'b00, 32'h0};
    tbl[21] = '{2'b00, 2'b00, 4'd0,  4'd0, 32'h0,        32'h0,        2'b00, 2'b01, 32'h0};

    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", reqReady, 2'b00);
    chk("rst_resp", respValid, 2'b00);
    chk("rst_init", initDone, 1'b0);
    chk("rst_we", ramWriteEnable, 1'b0);

    @(negedge clk);
    rst = 1'b0;
    reqValid = 2'b11;
    #1;
    for (int k = 0; k < N; k++) begin
      if (k > 0) drive(2'b11, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0);
      chk($sformatf("clr_idx%0d", k), ramIndex, k);
      chk($sformatf("clr_we%0d", k), ramWriteEnable, 1'b1);
      chk($sformatf("clr_wv%0d", k), ramWriteValue, 32'h0);
      chk($sformatf("clr_ready%0d", k), reqReady, 2'b00);
      chk($sformatf("clr_init%0d", k), initDone, 1'b0);
    end
    drive(2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0);
    chk("init_rise", initDone, 1'b1);

    for (int i = 0; i < N; i++) begin
      drive(2'b01, 2'b00, IW'(i), 4'd0, 32'h0, 32'h0);
      chk($sformatf("sweep_ready%0d", i), reqReady, 2'b01);
      if (i > 0) begin
        chk($sformatf("sweep_rv%0d", i), respValid, 2'b01);
        chk($sformatf("sweep_val%0d", i), respValue, 32'h0);
      end
    end
    drive(2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0);
    chk("sweep_rv_last", respValid, 2'b01);
    chk("sweep_val_last", respValue, 32'h0);

    for (int k = 0; k < 22; k++) begin
      drive(tbl[k].v, tbl[k].w, tbl[k].i0, tbl[k].i1, tbl[k].d0, tbl[k].d1);
      chk($sformatf("tbl%0d_ready", k), reqReady, tbl[k].rdy);
      chk($sformatf("tbl%0d_rv", k), respValid, tbl[k].rv);
      chk($sformatf("tbl%0d_we", k), ramWriteEnable, |(tbl[k].rdy & tbl[k].w));
      if (tbl[k].rv != 2'b00) chk($sformatf("tbl%0d_val", k), respValue, tbl[k].rval);
      if (tbl[k].rdy != 2'b00) chk($sformatf("tbl%0d_idx", k), ramIndex, tbl[k].rdy[1] ? tbl[k].i1 : tbl[k].i0);
    end

    for (int i = 0; i < N; i++) mm[i] = 32'h0;
    mm[5] = 32'hDEADBEEF;
    mm[3] = 32'h12345678;
    mm[15] = 32'hA5;
    mm[7] = 32'h22;
    rr = 1;
    pend = 2'b00;
    pval = '0;
    hold = 2'b00;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      for (int r = 0; r < 2; r++) begin
        if (!hold[r]) begin
          reqValid[r] = ($urandom % 10) < 7;
          reqWrite[r] = $urandom_range(0, 1);
          reqIndex[r] = IW'($urandom_range(0, N - 1));
          reqWriteValue[r] = $urandom;
        end
      end
      #1;
      g = reqValid == 2'b01 ? 0 : reqValid == 2'b10 ? 1 : reqValid == 2'b11 ? rr : -1;
      exp_rdy = g == 0 ? 2'b01 : g == 1 ? 2'b10 : 2'b00;
      chk($sformatf("rnd%0d_ready", c), reqReady, exp_rdy);
      chk($sformatf("rnd%0d_rv", c), respValid, pend);
      if (pend != 2'b00) chk($sformatf("rnd%0d_val", c), respValue, pval);
      chk($sformatf("rnd%0d_we", c), ramWriteEnable, g >= 0 && reqWrite[g]);
      pend = 2'b00;
      if (g >= 0) begin
        chk($sformatf("rnd%0d_idx", c), ramIndex, reqIndex[g]);
        if (reqWrite[g]) begin
          chk($sformatf("rnd%0d_wv", c), ramWriteValue, reqWriteValue[g]);
          mm[reqIndex[g]] = reqWriteValue[g];
        end else begin
          pend = exp_rdy;
          pval = mm[reqIndex[g]];
        end
        rr = 1 - g;
      end
      for (int r = 0; r < 2; r++) hold[r] = reqValid[r] && g != r;
    end

    drive(2'b01, 2'b00, 4'd2, 4'd0, 32'h0, 32'h0);
    chk("mid_ready", reqReady, 2'b01);
    @(negedge clk);
    rst = 1'b1;
    reqValid = 2'b00;
    #1;
    chk("mid_rst_rv", respValid, 2'b00);
    chk("mid_rst_init", initDone, 1'b0);
    chk("mid_rst_we", ramWriteEnable, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_after_rv", respValid, 2'b00);
    chk("mid_after_init", initDone, 1'b0);
    chk("mid_after_idx", ramIndex, 4'd0);
    chk("mid_after_we", ramWriteEnable, 1'b1);
    for (int k = 1; k < 5; k++) begin
      drive(2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0);
      chk($sformatf("part_idx%0d", k), ramIndex, k);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int k = 0; k < N; k++) begin
      if (k > 0) drive(2'b11, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0);
      chk($sformatf("reclr_idx%0d", k), ramIndex, k);
      chk($sformatf("reclr_we%0d", k), ramWriteEnable, 1'b1);
      chk($sformatf("reclr_ready%0d", k), reqReady, 2'b00);
    end
    drive(2'b11, 2'b00, 4'd5, 4'd9, 32'h0, 32'h0);
    chk("reclr_init", initDone, 1'b1);
    chk("reclr_rr0", reqReady, 2'b01);
    drive(2'b00, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0);
    chk("reclr_rv", respValid, 2'b01);
    chk("reclr_val", respValue, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
